// File: rtl/br_pkg.sv
// Shared definitions for the branch resolve unit.
//   br_op encodings : BR_NONE, BR_BEQ, BR_BNE, BR_J
//   state_t         : S_IDLE, S_REDIRECT, S_FLUSH (explicit legacy encodings)
package br_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_J    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/branch_resolve_unit_zero_flag.sv
// Zero detect on the ALU subtraction result (rs - rt).
//   operand [DATA_W-1:0] in  : ALU result
//   zero                 out : 1 when operand is all zeros
module zero_flag #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] operand,
  output logic              zero
);

  assign zero = ~|operand;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution at the EX/MEM boundary: decides taken/not-taken from the
// ALU zero flag, issues a redirect PC over valid/ready, then holds flush for
// FLUSH_CYCLES cycles after the redirect handshake.
//   clk, rst (sync, active-high)
//   in_valid/in_ready      : branch op handshake (br_op, alu_result, target)
//   redir_valid/redir_ready: redirect handshake carrying redir_pc
//   flush                  : squash younger IF/ID instructions
//   taken_cnt              : saturating count of taken branches
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        br_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [PC_W-1:0]   target,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [PC_W-1:0]   redir_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_cnt
);

  // Counter must still have at least one bit when FLUSH_CYCLES is 0.
  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_t          state;
  logic [FC_W-1:0] fcnt;
  logic            zero;
  logic            taken;
  logic            accept;

  zero_flag #(.DATA_W(DATA_W)) u_zero_flag (
    .operand (alu_result),
    .zero    (zero)
  );

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    in_ready    = (state == S_IDLE);
    redir_valid = (state == S_REDIRECT);
    flush       = (state == S_REDIRECT) || (state == S_FLUSH);
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fcnt      <= '0;
      redir_pc  <= '0;
      taken_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && taken) begin
            redir_pc <= target;
            if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            state <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redir_ready) begin
            fcnt  <= FC_W'(FLUSH_CYCLES);
            state <= (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          fcnt <= fcnt - 1'b1;
          if (fcnt == FC_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, redir_ready;
  logic [1:0]  br_op;
  logic [31:0] alu_result, target;
  logic        in_ready, redir_valid, flush;
  logic [31:0] redir_pc;
  logic [15:0] taken_cnt;

  // second instance: 2-bit counter, no flush cycles
  logic        rst2, in_valid2, redir_ready2;
  logic [1:0]  br_op2;
  logic [31:0] alu_result2, target2;
  logic        in_ready2, redir_valid2, flush2;
  logic [31:0] redir_pc2;
  logic [1:0]  taken_cnt2;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .PC_W(32), .FLUSH_CYCLES(FLUSH_N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .br_op(br_op),
    .alu_result(alu_result), .target(target), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc), .flush(flush), .taken_cnt(taken_cnt));

  branch_resolve_unit #(.DATA_W(32), .PC_W(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .br_op(br_op2),
    .alu_result(alu_result2), .target(target2), .redir_valid(redir_valid2),
    .redir_ready(redir_ready2), .redir_pc(redir_pc2), .flush(flush2), .taken_cnt(taken_cnt2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a pending redirect, how many flush cycles remain after
  // it, and a plain integer count clipped at the counter's maximum.
  bit          m_pending;
  logic [31:0] m_pc;
  int          m_flush_left;
  int          m_count;

  function automatic bit is_taken(input logic [1:0] op, input logic [31:0] a);
    if (op == 2'd1) return (a == 0);
    if (op == 2'd2) return (a != 0);
    return (op == 2'd3);
  endfunction

  function automatic bit m_idle();
    return !m_pending && m_flush_left == 0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_pending = 0; m_pc = '0; m_flush_left = 0; m_count = 0;
    end else if (m_pending) begin
      if (redir_ready) begin
        m_pending = 0;
        m_flush_left = FLUSH_N;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (in_valid && is_taken(br_op, alu_result)) begin
      m_pending = 1;
      m_pc = target;
      m_count = (m_count + 1 > 65535) ? 65535 : m_count + 1;
    end
  endtask

  task automatic compare_all();
    check("in_ready",    64'(in_ready),    64'(m_idle()));
    check("redir_valid", 64'(redir_valid), 64'(m_pending));
    check("flush",       64'(flush),       64'(m_pending || m_flush_left > 0));
    check("redir_pc",    64'(redir_pc),    64'(m_pc));
    check("taken_cnt",   64'(taken_cnt),   64'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] alu;
    logic [31:0] tgt;
    bit          exp_taken;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int exp_cnt;
    int acc2;
    rst = 1; in_valid = 0; redir_ready = 0; br_op = 0; alu_result = 0; target = 0;
    rst2 = 1; in_valid2 = 0; redir_ready2 = 0; br_op2 = 0; alu_result2 = 0; target2 = 0;
    m_pending = 0; m_pc = '0; m_flush_left = 0; m_count = 0;
    tick();
    tick();
    rst = 0; rst2 = 0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_redir_valid", 64'(redir_valid), 64'd0);
    check("reset_flush", 64'(flush), 64'd0);
    check("reset_taken_cnt", 64'(taken_cnt), 64'd0);
    check("reset_redir_pc", 64'(redir_pc), 64'd0);

    // Plan test 1: beq taken, then exactly two flush cycles.
    in_valid = 1; br_op = 2'd1; alu_result = 32'h0; target = 32'h0040_0020; redir_ready = 1;
    tick();
    in_valid = 0;
    check("t1_redir_valid", 64'(redir_valid), 64'd1);
    check("t1_redir_pc", 64'(redir_pc), 64'h0040_0020);
    check("t1_flush0", 64'(flush), 64'd1);
    tick();
    check("t1_flush1", 64'(flush), 64'd1);
    check("t1_valid_drop", 64'(redir_valid), 64'd0);
    check("t1_busy1", 64'(in_ready), 64'd0);
    tick();
    check("t1_flush2", 64'(flush), 64'd1);
    tick();
    check("t1_flush_end", 64'(flush), 64'd0);
    check("t1_ready_back", 64'(in_ready), 64'd1);
    check("t1_cnt", 64'(taken_cnt), 64'd1);

    // Table of single ops issued from IDLE with redir_ready=1.
    vecs[0] = '{2'd1, 32'h8000_0000, 32'h0000_0100, 1'b0};
    vecs[1] = '{2'd2, 32'h0000_0000, 32'h0000_0200, 1'b0};
    vecs[2] = '{2'd2, 32'h0000_0001, 32'h0000_1000, 1'b1};
    vecs[3] = '{2'd0, 32'h0000_0000, 32'h0000_0300, 1'b0};
    vecs[4] = '{2'd3, 32'hDEAD_BEEF, 32'h0040_1000, 1'b1};
    vecs[5] = '{2'd1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1};
    vecs[6] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0004, 1'b1};
    vecs[7] = '{2'd0, 32'h1234_5678, 32'h0000_0008, 1'b0};
    exp_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc_before;
      pc_before = redir_pc;
      in_valid = 1; br_op = vecs[i].op; alu_result = vecs[i].alu; target = vecs[i].tgt;
      redir_ready = 1;
      tick();
      in_valid = 0;
      if (vecs[i].exp_taken) exp_cnt++;
      check($sformatf("vec%0d_redir_valid", i), 64'(redir_valid), 64'(vecs[i].exp_taken));
      check($sformatf("vec%0d_redir_pc", i), 64'(redir_pc),
            64'(vecs[i].exp_taken ? vecs[i].tgt : pc_before));
      check($sformatf("vec%0d_cnt", i), 64'(taken_cnt), 64'(exp_cnt));
      for (int k = 0; k < 10 && !in_ready; k++) tick();
      check($sformatf("vec%0d_drain", i), 64'(in_ready), 64'd1);
    end

    // j with redir_ready held low for 3 cycles; target changes ignored.
    in_valid = 1; br_op = 2'd3; target = 32'h0000_ABC0; redir_ready = 0;
    tick();
    for (int c = 0; c < 3; c++) begin
      target = 32'h5555_0000 + 32'(c);
      br_op = 2'd3;
      check("stall_valid", 64'(redir_valid), 64'd1);
      check("stall_pc", 64'(redir_pc), 64'h0000_ABC0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      if (c < 2) tick();
    end
    in_valid = 0; redir_ready = 1;
    tick();
    check("stall_hs_flush", 64'(flush), 64'd1);
    check("stall_hs_valid", 64'(redir_valid), 64'd0);
    tick();
    check("stall_flush2", 64'(flush), 64'd1);
    tick();
    check("stall_idle", 64'(in_ready), 64'd1);

    // Reset while in REDIRECT drops the pending redirect.
    in_valid = 1; br_op = 2'd3; target = 32'h0000_7770; redir_ready = 0;
    tick();
    in_valid = 0;
    check("rst_pre_valid", 64'(redir_valid), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_valid", 64'(redir_valid), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cnt", 64'(taken_cnt), 64'd0);

    // Saturating 2-bit counter, no flush cycles: 5 back-to-back taken j.
    in_valid2 = 1; br_op2 = 2'd3; redir_ready2 = 1;
    acc2 = 0;
    for (int b = 0; b < 5; b++) begin
      target2 = 32'h100 * 32'(b + 1);
      tick();
      acc2++;
      check("sat_valid", 64'(redir_valid2), 64'd1);
      check("sat_pc", 64'(redir_pc2), 64'(32'h100 * 32'(b + 1)));
      check("sat_cnt", 64'(taken_cnt2), 64'(acc2 > 3 ? 3 : acc2));
      tick();
      check("sat_no_flush", 64'(flush2), 64'd0);
      check("sat_ready", 64'(in_ready2), 64'd1);
    end
    in_valid2 = 0;
    check("sat_final", 64'(taken_cnt2), 64'd3);

    // Randomized traffic against the model.
    for (int r = 0; r < 600; r++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      br_op = 2'($urandom_range(0, 3));
      alu_result = ($urandom_range(0, 9) < 3) ? 32'h0 : $urandom;
      target = $urandom;
      redir_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 99) < 2);
      tick();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the ALU subtraction result (rs − rt) for conditional branches and decides taken/not-taken from its zero flag.
- On a taken branch, issues a redirect PC to the fetch stage over a valid/ready handshake.
- Holds the pipeline flush for a programmable number of cycles.
- Sits at the EX/MEM boundary of the pipelined MIPS core, downstream of the ALU.

Parameters:
- DATA_W, 32, width of the ALU result operand.
- PC_W, 32, width of branch target / redirect PC.
- FLUSH_CYCLES, 2, cycles flush stays asserted after redirect is accepted (0 allowed).
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  branch op presented this cycle.
- in_ready  out  1  unit can accept a branch op.
- br_op  in  2  00 none, 01 beq, 10 bne, 11 j (unconditional).
- alu_result  in  DATA_W  rs − rt from ALU.
- target  in  PC_W  computed branch/jump target.
- redir_valid  out  1  redirect request to fetch.
- redir_ready  in  1  fetch accepts redirect.
- redir_pc  out  PC_W  redirect address, stable while redir_valid=1.
- flush  out  1  squash younger IF/ID instructions.
- taken_cnt  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset: all outputs 0, except in_ready=1 in the cycle after reset. State=IDLE, flush counter 0.
- zero = ~|alu_result, computed combinationally.
- taken = (beq & zero) | (bne & ~zero) | j. br_op=00 is never taken.
- IDLE:
  - in_ready=1, redir_valid=0, flush=0.
  - Accept occurs when in_valid & in_ready.
  - Accept with taken: latch target into redir_pc, increment taken_cnt (saturating at all-ones), go to REDIRECT.
  - Accept with not taken: remain in IDLE, no output change.
- REDIRECT:
  - in_ready=0, redir_valid=1, flush=1.
  - redir_pc is held constant.
  - While redir_ready=0: stay in REDIRECT.
  - On redir_ready=1: load counter with FLUSH_CYCLES. Go to FLUSH if FLUSH_CYCLES>0, else go to IDLE.
- FLUSH:
  - in_ready=0, redir_valid=0, flush=1.
  - Counter decrements each cycle. Go to IDLE on the cycle the counter reads 1.
  - flush is therefore high for exactly FLUSH_CYCLES cycles after the handshake cycle.
- Latency: a taken branch accepted on edge N gives redir_valid=1 after edge N; the earliest handshake is that same cycle.
- Inputs while in_ready=0 are ignored; no queuing.
- rst in any state returns to IDLE on the next edge and discards any pending redirect. taken_cnt clears.
- alu_result is examined only on the accept cycle. Later changes have no effect.

Decomposition:
- Shared package br_pkg: br_op encodings (BR_NONE, BR_BEQ, BR_BNE, BR_J) and the state enum (S_IDLE, S_REDIRECT, S_FLUSH).
- One sub-module, zero_flag: parameterized DATA_W reduction-NOR producing zero, instantiated once.
- FSM, flush counter and taken counter live in branch_resolve_unit.

Test Plan:
- beq, alu_result=0x00000000, target=0x00400020, redir_ready=1 → next cycle redir_valid=1, redir_pc=0x00400020, flush=1. Then flush=1 for 2 more cycles, then in_ready=1; taken_cnt=1.
- beq with alu_result=0x80000000; bne with alu_result=0 → no redir_valid, in_ready stays 1, taken_cnt unchanged.
- bne with alu_result=0x00000001, target=0x1000 → redirect to 0x1000. Same cycle with br_op=00 and alu_result=0 → no redirect.
- Taken j with redir_ready low for 3 cycles → redir_valid and redir_pc stable 3 cycles, in_ready=0, target changes ignored. Handshake on 4th cycle, then 2 flush cycles.
- rst asserted during REDIRECT → next cycle redir_valid=0, flush=0, in_ready=1, taken_cnt=0.
- CNT_W=2, FLUSH_CYCLES=0: 5 taken branches back-to-back with redir_ready=1 → taken_cnt sticks at 3. Each redirect returns to IDLE with no FLUSH cycles.
